// File: rtl/tomasulo_core.sv
// Minimal Tomasulo engine: fixed program queue, 8 tagged registers, three add/sub
// reservation stations, one multi-cycle ALU and a single CDB. Trace: TOMASULO_TRACE_EN.
module tomasulo_core #(
  parameter int XLEN    = 16,
  parameter int ALU_LAT = 2,
  parameter int QDEPTH  = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Pop,
  input  logic [2:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            issued,
  output logic            queue_empty,
  output logic            busy,
  output logic            cdb_valid,
  output logic [1:0]      cdb_tag,
  output logic [XLEN-1:0] cdb_value
);
  localparam int HW = $clog2(QDEPTH + 1);
  localparam int CW = $clog2(ALU_LAT + 1);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_HALT = 3'b111;

  // Instruction word bits [15:4]; the low nibble carries nothing.
  function automatic logic [15:4] prog(input logic [HW-1:0] idx);
    logic [15:4] w;
    case (int'(idx))
      0, 2, 3, 4, 5: w = {OP_ADD, 3'd0, 3'd1, 3'd2};
      1, 6:          w = {OP_SUB, 3'd0, 3'd1, 3'd2};
      default:       w = {OP_HALT, 9'd0};
    endcase
    return w;
  endfunction

  function automatic logic signed [XLEN-1:0] alu(input logic is_sub,
                                                  input logic signed [XLEN-1:0] a,
                                                  input logic signed [XLEN-1:0] b);
    return is_sub ? a - b : a + b;
  endfunction

  logic [HW-1:0]          head;
  logic [15:4]            inst;
  logic [XLEN-1:0]        regs [8];
  logic [7:0]             tag_v;
  logic [1:0]             tag [8];
  logic [2:0]             rs_busy, rs_exec, rs_sub, qj_v, qk_v;
  logic [1:0]             qj [3];
  logic [1:0]             qk [3];
  logic signed [XLEN-1:0] vj [3];
  logic signed [XLEN-1:0] vk [3];
  logic                   unit_busy;
  logic [CW-1:0]          cnt;
  logic [1:0]             unit_rs;
  logic signed [XLEN-1:0] res_p0;
  logic [2:0]             free_mask, src_j, src_k, dst;
  logic                   free_ok, start_ok, do_issue, do_start;
  logic [1:0]             free_idx, start_idx;
  logic                   j_fwd, k_fwd, j_wait, k_wait;
  logic signed [XLEN-1:0] j_val, k_val;

  always_comb begin
    inst        = prog(head);
    dst         = inst[12:10];
    src_j       = inst[9:7];
    src_k       = inst[6:4];
    queue_empty = (head == HW'(QDEPTH)) || (inst[15:13] == OP_HALT);
    // A station broadcasting now is freed at this edge and may be refilled at once.
    free_mask   = ~rs_busy | (cdb_valid ? (3'b001 << cdb_tag) : 3'b000);
    free_ok     = 1'b0;
    free_idx    = 2'd0;
    start_ok    = 1'b0;
    start_idx   = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_ok  = 1'b1;
        free_idx = 2'(i);
      end
      if (rs_busy[i] && !rs_exec[i] && !qj_v[i] && !qk_v[i]) begin
        start_ok  = 1'b1;
        start_idx = 2'(i);
      end
    end
    do_issue = Pop && !queue_empty && free_ok;
    do_start = !unit_busy && start_ok;
    j_fwd    = tag_v[src_j] && cdb_valid && (tag[src_j] == cdb_tag);
    k_fwd    = tag_v[src_k] && cdb_valid && (tag[src_k] == cdb_tag);
    j_wait   = tag_v[src_j] && !j_fwd;
    k_wait   = tag_v[src_k] && !k_fwd;
    j_val    = j_fwd ? cdb_value : regs[src_j];
    k_val    = k_fwd ? cdb_value : regs[src_k];
  end

  assign dbg_data = regs[dbg_addr];
  assign busy     = (|rs_busy) || unit_busy;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      head      <= '0;
      issued    <= 1'b0;
      tag_v     <= '0;
      rs_busy   <= '0;
      rs_exec   <= '0;
      qj_v      <= '0;
      qk_v      <= '0;
      unit_busy <= 1'b0;
      cnt       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      for (int n = 0; n < 8; n++) begin
        regs[n] <= XLEN'(n);
        tag[n]  <= '0;
      end
    end else begin
      issued    <= do_issue;
      cdb_valid <= 1'b0;
      // Writeback stage: consume the broadcast held during this cycle
      if (cdb_valid) begin
        rs_busy[cdb_tag] <= 1'b0;
        rs_exec[cdb_tag] <= 1'b0;
        for (int i = 0; i < 3; i++) begin
          if (qj_v[i] && qj[i] == cdb_tag) qj_v[i] <= 1'b0;
          if (qk_v[i] && qk[i] == cdb_tag) qk_v[i] <= 1'b0;
        end
        for (int n = 0; n < 8; n++) begin
          if (tag_v[n] && tag[n] == cdb_tag) begin
            regs[n]  <= cdb_value;
            tag_v[n] <= 1'b0;
          end
        end
      end
      // Execute stage: count down, broadcast on the final edge
      if (unit_busy) begin
        if (cnt == CW'(1)) begin
          cdb_valid <= 1'b1;
          cdb_tag   <= unit_rs;
          cdb_value <= res_p0;
          unit_busy <= 1'b0;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end else if (do_start) begin
        unit_busy          <= 1'b1;
        cnt                <= CW'(ALU_LAT);
        rs_exec[start_idx] <= 1'b1;
      end
      // Issue stage: later assignments override the writeback of the same edge
      if (do_issue) begin
        rs_busy[free_idx] <= 1'b1;
        rs_exec[free_idx] <= 1'b0;
        qj_v[free_idx]    <= j_wait;
        qk_v[free_idx]    <= k_wait;
        tag_v[dst]        <= 1'b1;
        tag[dst]          <= free_idx;
        head              <= head + HW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    for (int i = 0; i < 3; i++) begin
      if (cdb_valid && qj_v[i] && qj[i] == cdb_tag) vj[i] <= cdb_value;
      if (cdb_valid && qk_v[i] && qk[i] == cdb_tag) vk[i] <= cdb_value;
    end
    if (do_start) begin
      res_p0  <= alu(rs_sub[start_idx], vj[start_idx], vk[start_idx]);
      unit_rs <= start_idx;
    end
    if (do_issue) begin
      rs_sub[free_idx] <= (inst[15:13] == OP_SUB);
      vj[free_idx]     <= j_val;
      vk[free_idx]     <= k_val;
      qj[free_idx]     <= tag[src_j];
      qk[free_idx]     <= tag[src_k];
    end
  end

`ifdef TOMASULO_TRACE_EN
  always @(posedge Clock) begin
    if (Reset && do_issue)
      $display("%0t issue q%0d op%0d rs%0d", $time, head, inst[15:13], free_idx);
    if (Reset && cdb_valid)
      $display("%0t cdb tag%0d value %h", $time, cdb_tag, cdb_value);
  end
`else
`endif

endmodule

// File: tb/tb_tomasulo_core.sv
// Bench for tomasulo_core: randomized Pop/debug stimulus against a transaction-level
// model of the fixed program's issue, execute and writeback rules.
module tb_tomasulo_core;
  localparam int XLEN = 16, ALU_LAT = 2, QDEPTH = 8;

  logic            Clock = 1'b0, Reset = 1'b0, Pop = 1'b0;
  logic [2:0]      dbg_addr = 3'd0;
  logic [XLEN-1:0] dbg_data, cdb_value;
  logic            issued, queue_empty, busy, cdb_valid;
  logic [1:0]      cdb_tag;

  int n_checks = 0, n_fail = 0, cyc = 0;
  int bc_total = 0, bc_3 = 0, bc_f = 0;
  int iss_q[$];
  int cdb_q[$];

  // Reference model state: program head, registers with producer tags (-1 none),
  // stations holding operand values or the tag they wait on, and the ALU slot.
  int m_head, m_r[8], m_tg[8];
  bit m_rb[3], m_rx[3], m_sub[3];
  int m_a[3], m_b[3], m_wa[3], m_wb[3];
  int m_urs, m_left, m_res;
  bit m_cdb, m_iss;
  int m_tag, m_val;

  tomasulo_core #(.XLEN(XLEN), .ALU_LAT(ALU_LAT), .QDEPTH(QDEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Pop(Pop), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .issued(issued), .queue_empty(queue_empty), .busy(busy), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value));

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic bit m_empty();
    return (m_head >= QDEPTH) || (m_head == 7);
  endfunction

  function automatic logic [21:0] m_out();
    bit b;
    b = (m_urs >= 0) || m_rb[0] || m_rb[1] || m_rb[2];
    return {m_iss, b, m_empty(), m_cdb, 2'(m_tag), 16'(m_val)};
  endfunction

  function automatic logic [21:0] obs();
    return {issued, busy, queue_empty, cdb_valid, cdb_tag, cdb_value};
  endfunction

  task automatic m_reset();
    m_head = 0;
    for (int n = 0; n < 8; n++) begin m_r[n] = n; m_tg[n] = -1; end
    for (int i = 0; i < 3; i++) begin m_rb[i] = 0; m_rx[i] = 0; m_wa[i] = -1; m_wb[i] = -1; end
    m_urs = -1; m_left = 0; m_res = 0;
    m_cdb = 0; m_iss = 0; m_tag = 0; m_val = 0;
  endtask

  // One clock edge of the architecture: retire the visible broadcast, advance or
  // start the ALU, then issue the head instruction into the lowest free station.
  task automatic m_edge(input bit pop);
    bit oc;
    int ot, ov, st, f;
    oc = m_cdb; ot = m_tag; ov = m_val;
    st = -1;
    if (m_urs < 0)
      for (int i = 2; i >= 0; i--)
        if (m_rb[i] && !m_rx[i] && m_wa[i] < 0 && m_wb[i] < 0) st = i;
    m_cdb = 0;
    if (m_urs >= 0) begin
      if (m_left == 1) begin
        m_cdb = 1; m_tag = m_urs; m_val = m_res; m_urs = -1;
      end else m_left--;
    end
    if (oc) begin
      for (int i = 0; i < 3; i++) begin
        if (m_rb[i] && m_wa[i] == ot) begin m_a[i] = ov; m_wa[i] = -1; end
        if (m_rb[i] && m_wb[i] == ot) begin m_b[i] = ov; m_wb[i] = -1; end
      end
      m_rb[ot] = 0; m_rx[ot] = 0;
      for (int n = 0; n < 8; n++)
        if (m_tg[n] == ot) begin m_r[n] = ov; m_tg[n] = -1; end
    end
    if (st >= 0) begin
      m_rx[st] = 1; m_urs = st; m_left = ALU_LAT;
      m_res = (m_sub[st] ? m_a[st] - m_b[st] : m_a[st] + m_b[st]) & 'hFFFF;
    end
    f = -1;
    for (int i = 2; i >= 0; i--) if (!m_rb[i]) f = i;
    m_iss = pop && !m_empty() && (f >= 0);
    if (m_iss) begin
      m_rb[f] = 1; m_rx[f] = 0; m_sub[f] = (m_head == 1 || m_head == 6);
      m_a[f] = m_r[1]; m_wa[f] = m_tg[1];
      m_b[f] = m_r[2]; m_wb[f] = m_tg[2];
      m_tg[0] = f;
      m_head++;
    end
  endtask

  task automatic step(input bit pop);
    Pop = pop;
    dbg_addr = 3'($urandom_range(0, 7));
    m_edge(pop);
    @(posedge Clock);
    #1;
    cyc++;
    if (cdb_valid) begin
      bc_total++;
      if (cdb_value == 16'h0003) bc_3++;
      if (cdb_value == 16'hFFFF) bc_f++;
      cdb_q.push_back(cyc);
    end
    if (issued) iss_q.push_back(cyc);
  endtask

  task automatic do_reset();
    Pop = 1'b0;
    Reset = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    m_reset();
    bc_total = 0; bc_3 = 0; bc_f = 0; cyc = 0;
    iss_q.delete();
    cdb_q.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1;
      n_checks++;
      if (dbg_data !== 16'(a)) begin
        n_fail++; $display("FAIL reset_reg R%0d got %h want %h", a, dbg_data, 16'(a));
      end
    end
    n_checks++;
    if ({issued, busy, queue_empty, cdb_valid, cdb_tag, cdb_value} !== 22'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", obs());
    end
    @(negedge Clock);
    Reset = 1'b1;
    m_reset();
  endtask

  task automatic test_pop_idle();
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      n_checks++;
      if ({issued, busy, cdb_valid} !== 3'b000 || obs() !== m_out()) begin
        n_fail++; $display("FAIL pop_idle cycle %0d got %h want %h", k, obs(), m_out());
      end
    end
  endtask

  task automatic test_full_run();
    int budget;
    do_reset();
    budget = 0;
    do begin
      step(1'b1);
      budget++;
      n_checks++;
      if (obs() !== m_out()) begin
        n_fail++; $display("FAIL full_run cycle %0d got %h want %h", cyc, obs(), m_out());
      end
      n_checks++;
      if (dbg_data !== 16'(m_r[dbg_addr])) begin
        n_fail++; $display("FAIL full_run_dbg R%0d got %h want %h", dbg_addr, dbg_data, 16'(m_r[dbg_addr]));
      end
    end while (budget < 200 && !(queue_empty && !busy));
    n_checks++;
    if (budget >= 200) begin n_fail++; $display("FAIL full_run_drain got timeout want drained"); end
    n_checks++;
    if (bc_total != 7 || bc_3 != 5 || bc_f != 2) begin
      n_fail++; $display("FAIL full_run_broadcasts got %0d/%0d/%0d want 7/5/2", bc_total, bc_3, bc_f);
    end
    for (int a = 0; a < 3; a++) begin
      dbg_addr = 3'(a);
      #1;
      n_checks++;
      if (dbg_data !== ((a == 0) ? 16'hFFFF : 16'(a))) begin
        n_fail++; $display("FAIL final_reg R%0d got %h", a, dbg_data);
      end
    end
    n_checks++;
    if (iss_q.size() < 4 || cdb_q.size() < 1) begin
      n_fail++; $display("FAIL issue_pattern got %0d issues want at least 4", iss_q.size());
    end else begin
      n_checks++;
      if (iss_q[0] != 1 || iss_q[1] != 2 || iss_q[2] != 3) begin
        n_fail++; $display("FAIL issue_consecutive got %0d %0d %0d want 1 2 3", iss_q[0], iss_q[1], iss_q[2]);
      end
      n_checks++;
      if (iss_q[3] != cdb_q[0] + 1) begin
        n_fail++; $display("FAIL fourth_issue got %0d want %0d", iss_q[3], cdb_q[0] + 1);
      end
    end
  endtask

  task automatic test_pop_pause();
    int budget;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(k < 2);
      n_checks++;
      if (obs() !== m_out()) begin
        n_fail++; $display("FAIL pause cycle %0d got %h want %h", cyc, obs(), m_out());
      end
    end
    n_checks++;
    if (bc_total != 2 || iss_q.size() != 2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pause_idle got bc=%0d iss=%0d busy=%b want 2 2 0", bc_total, iss_q.size(), busy);
    end
    budget = 0;
    do begin
      step(1'b1);
      budget++;
      n_checks++;
      if (obs() !== m_out()) begin
        n_fail++; $display("FAIL resume cycle %0d got %h want %h", cyc, obs(), m_out());
      end
    end while (budget < 200 && !(queue_empty && !busy));
    n_checks++;
    if (bc_total != 7 || iss_q.size() != 7 || iss_q[2] != 13) begin
      n_fail++; $display("FAIL resume_total got bc=%0d iss=%0d want 7 7 resume@13", bc_total, iss_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      n_checks++;
      if (obs() !== m_out()) begin
        n_fail++; $display("FAIL pre_reset cycle %0d got %h want %h", cyc, obs(), m_out());
      end
    end
    #2;
    Reset = 1'b0;
    dbg_addr = 3'd5;
    #1;
    n_checks++;
    if ({issued, busy, cdb_valid, cdb_tag, cdb_value} !== 21'd0) begin
      n_fail++; $display("FAIL async_reset got %h want 0", obs());
    end
    n_checks++;
    if (dbg_data !== 16'd5) begin n_fail++; $display("FAIL async_reset_reg got %h want 0005", dbg_data); end
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    m_reset();
    bc_total = 0; bc_3 = 0; bc_f = 0; cyc = 0;
    iss_q.delete();
    cdb_q.delete();
    budget = 0;
    do begin
      step(1'b1);
      budget++;
      n_checks++;
      if (obs() !== m_out()) begin
        n_fail++; $display("FAIL rerun cycle %0d got %h want %h", cyc, obs(), m_out());
      end
    end while (budget < 200 && !(queue_empty && !busy));
    n_checks++;
    if (bc_total != 7 || iss_q.size() != 7 || iss_q[0] != 1) begin
      n_fail++; $display("FAIL rerun_total got bc=%0d iss=%0d want 7 7", bc_total, iss_q.size());
    end
  endtask

  task automatic test_random_pop();
    int budget;
    do_reset();
    budget = 0;
    do begin
      step($urandom_range(0, 3) != 0);
      budget++;
      n_checks++;
      if (obs() !== m_out()) begin
        n_fail++; $display("FAIL random cycle %0d got %h want %h", cyc, obs(), m_out());
      end
      n_checks++;
      if (dbg_data !== 16'(m_r[dbg_addr])) begin
        n_fail++; $display("FAIL random_dbg R%0d got %h want %h", dbg_addr, dbg_data, 16'(m_r[dbg_addr]));
      end
    end while (budget < 400 && !(queue_empty && !busy));
    n_checks++;
    if (budget >= 400 || bc_total != 7 || bc_3 != 5 || bc_f != 2) begin
      n_fail++; $display("FAIL random_total got bc=%0d/%0d/%0d want 7/5/2", bc_total, bc_3, bc_f);
    end
  endtask

  initial begin
    test_reset();
    test_pop_idle();
    test_full_run();
    test_pop_pause();
    test_reset_mid();
    for (int r = 0; r < 3; r++) test_random_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tomasulo_core.md
Name: tomasulo_core

Overview:
- Minimal Tomasulo out-of-order execution core.
- Contains a preloaded instruction queue, an 8-entry register file with register-status tags, three add/sub reservation stations (RS), one non-pipelined integer add/sub unit and a single common data bus (CDB).
- Dispatch is gated by the Pop input.
- Top-level execution engine of the processor lab; CDB and debug ports provide observability.

Parameters:
- XLEN, 16, data width of registers and results.
- ALU_LAT, 2, execution cycles of the add/sub unit (must be at least 1).
- QDEPTH, 8, number of instruction-queue entries.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Pop  input  1  level-sensitive dispatch enable; one issue attempt per cycle while high.
- dbg_addr  input  3  register-file debug read address.
- dbg_data  output  XLEN  combinational value of R[dbg_addr].
- issued  output  1  registered; high for the cycle after an instruction issued.
- queue_empty  output  1  head points at HALT or at index QDEPTH.
- busy  output  1  any RS busy or the unit executing.
- cdb_valid  output  1  registered one-cycle broadcast strobe.
- cdb_tag  output  2  RS index that produced the result (0..2).
- cdb_value  output  XLEN  broadcast result.

Behaviour:
- Instruction format, 16 bits: [15:13] op (000 ADD, 001 SUB, 111 HALT), [12:10] rd, [9:7] rs, [6:4] rt, [3:0] unused.
- Queue content is fixed at reset:
  - Index 0..6: ADD, SUB, ADD, ADD, ADD, ADD, SUB, each with rd=R0, rs=R1, rt=R2.
  - Index 7: HALT.
  - HALT is never issued.
- Reset (Reset=0, asynchronous):
  - Head = 0; R[n] = n for n = 0..7; all register tags invalid; all RS free; unit idle.
  - issued = 0, cdb_valid = 0, cdb_tag = 0, cdb_value = 0, busy = 0.
- Issue, at each rising edge:
  - Condition: Pop=1, not queue_empty, and a free RS exists (lowest free index chosen). Otherwise the instruction stalls; head holds.
  - The RS captures op and each source operand as either the register value or the producing tag (Qj/Qk).
  - If the source's producing tag is broadcasting on the CDB in that same cycle, the RS captures the CDB value instead.
  - Tag[rd] is set to the RS index (latest issuer wins, WAW-safe). Head increments.
- Execute:
  - When the unit is idle, the lowest-index busy RS with both operands ready starts.
  - It must not start in the same edge it was issued.
  - ADD computes rs+rt; SUB computes rs-rt; both modulo 2^XLEN.
  - The unit stays occupied for ALU_LAT cycles.
  - At the final edge it drives cdb_valid=1, cdb_tag, cdb_value for exactly one cycle, and becomes idle.
- Writeback, at the edge ending a cdb_valid cycle:
  - Every RS waiting on cdb_tag captures cdb_value.
  - R[rd] is written only if tag[rd] still equals cdb_tag; that tag is then cleared.
  - The producing RS is freed and may be reallocated at that same edge.
- Simultaneous issue and broadcast: the issuing RS always observes the broadcast value.
- Pop deasserted: issue pauses; execution and broadcasts in flight continue.
- Pop while queue_empty: no effect.
- Reset asserted mid-operation: immediately returns to the reset state; in-flight work is discarded.

Optional Feature:
- TOMASULO_TRACE_EN defined: simulation-only $display for each issue (time, queue index, op, RS index) and each broadcast (time, tag, value).
- Undefined: no display statements; RTL behaviour is identical either way.

Test Plan:
- Reset held for 2 cycles → dbg_data reads 0..7 for R0..R7; cdb_valid = 0; busy = 0; queue_empty = 0.
- Reset released, Pop=0 for 4 cycles → issued stays 0; busy = 0; no cdb_valid.
- Pop=1 held → 7 broadcasts in program order with values 0003, FFFF, 0003, 0003, 0003, 0003, FFFF; then queue_empty = 1 and busy falls to 0.
  - Final state: R0 = FFFF; R1 = 1; R2 = 2.
- Pop=1 held, issue pattern → first three instructions issue on consecutive cycles; the fourth stalls until the first RS is freed by its broadcast.
- Pop dropped after the 2nd issue for 10 cycles → exactly 2 broadcasts, then idle; re-raising Pop resumes from instruction index 2.
- Reset pulsed low mid-stream → outputs return to reset values within the reset pulse, without waiting for a clock edge; after release, the program reruns from index 0.
